pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage core.
- Sequences the PC register, the IF/ID register (stall/flush) and the ID/EX register (bubble insert).
- Resolves four hazard sources under a fixed priority:
  - EX-stage taken branch/jump flush
  - multi-cycle multiply/divide occupancy
  - load-use data hazard
  - instruction-memory wait
- Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MDU_CYCLES, 32: EX-stage occupancy of a mult/div instruction in cycles; legal range 2..255.
- CNT_W, 16: width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock, all state updates on posedge
- resetn  in  1  reset; synchronous, active-low
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_mdu  in  1  ID instruction is mult/div (valid only when not flushed)
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  5  destination register of the EX load
- jmp  in  1  EX resolved taken branch/jump this cycle
- imem_ready  in  1  fetch data valid this cycle
- pc_we  out  1  PC register write enable
- ifid_stall  out  1  IF/ID holds its contents
- ifid_flush  out  1  IF/ID loads pc=0, inst=0 (nop)
- idex_bubble  out  1  ID/EX loads nop instead of ID output
- mdu_busy  out  1  high while in MDU_WAIT
- stall_cnt  out  CNT_W  saturating count of cycles with pc_we=0

Behaviour:
- State machine, 2 states: RUN, MDU_WAIT. State, mdu_cnt (8 bit) and stall_cnt are registered. Remaining outputs are combinational from state and inputs.
- Reset (resetn=0 at posedge):
  - state=RUN, mdu_cnt=0, stall_cnt=0.
  - Combinational outputs while resetn=0: pc_we=0, ifid_stall=0, ifid_flush=1, idex_bubble=1, mdu_busy=0.
  - Reset mid-MDU_WAIT aborts the wait immediately.
- Load-use detect: lu = ex_mem_read & ex_rt!=0 & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- RUN output priority, first match wins:
  1. jmp=1: pc_we=1, ifid_flush=1, idex_bubble=1, ifid_stall=0. id_mdu and lu are ignored (ID instruction is squashed). No state change.
  2. lu=1: pc_we=0, ifid_stall=1, idex_bubble=1. Exactly one bubble per load; the next cycle the load is in MEM so lu deasserts. id_mdu is ignored this cycle and re-evaluated next cycle.
  3. id_mdu=1: normal advance (pc_we=1 subject to rule 4, ID/EX takes the mult/div). Next state MDU_WAIT, mdu_cnt <= MDU_CYCLES-1.
  4. imem_ready=0: pc_we=0, ifid_flush=1, ifid_stall=0, idex_bubble=0. Combined with rule 3: PC held, mult/div still issues, IF/ID gets nop.
  5. Otherwise: pc_we=1, all other controls 0.
- MDU_WAIT:
  - Outputs: mdu_busy=1, pc_we=0, ifid_stall=1, idex_bubble=1. jmp and lu are ignored (EX holds the MDU op or bubbles, so neither can be legitimately asserted).
  - mdu_cnt decrements each cycle. When mdu_cnt==1, next state RUN.
  - Stall length = MDU_CYCLES-1 cycles; the instruction after the mult/div enters EX exactly MDU_CYCLES cycles after the mult/div did.
- Invariants:
  - ifid_stall and ifid_flush are never both 1.
  - pc_we=0 whenever ifid_stall=1.
- stall_cnt: +1 on every posedge with resetn=1 and pc_we=0. Saturates at all-ones; no wrap.

Test Plan:
- Load-use: lw $5 in EX (ex_mem_read=1, ex_rt=5), ID add with id_rs=5 -> one cycle of pc_we=0, ifid_stall=1, idex_bubble=1; next cycle all 0, pc_we=1; stall_cnt=1.
- $0 exclusion: ex_rt=0, id_rs=0, ex_mem_read=1 -> no stall, pc_we=1.
- Jump priority: jmp=1 together with lu=1 and id_mdu=1 -> ifid_flush=1, idex_bubble=1, pc_we=1; state stays RUN; mdu_busy stays 0.
- MDU with MDU_CYCLES=4: id_mdu pulse in RUN -> mdu_busy=1 for exactly 3 cycles with pc_we=0 and ifid_stall=1, then RUN; stall_cnt=3. jmp pulsed mid-wait -> no effect.
- Imem wait: imem_ready=0 for 2 cycles -> pc_we=0, ifid_flush=1, idex_bubble=0 both cycles; resume on imem_ready=1.
- Reset mid-wait: resetn=0 on the 2nd MDU_WAIT cycle -> next cycle state=RUN, mdu_busy=0, stall_cnt=0; saturation check with CNT_W=4: 20 stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard controller: PC/IF-ID/ID-EX sequencing
// Fixed priority: jump flush, load-use bubble, mult/div issue, imem wait.
module pipe_hazard_ctrl #(
  parameter int MDU_CYCLES = 32,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_mdu,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             jmp,
  input  logic             imem_ready,
  output logic             pc_we,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN, MDU_WAIT} state_t;

  localparam logic [7:0] MDU_LOAD = 8'(MDU_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] mdu_cnt, mdu_cnt_nxt;
  logic       lu;

  // $0 is never a real dependency, so a load targeting it cannot hazard.
  assign lu = ex_mem_read && (ex_rt != 5'd0) &&
              ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= RUN;
      mdu_cnt   <= 8'd0;
      stall_cnt <= '0;
    end else begin
      state   <= state_nxt;
      mdu_cnt <= mdu_cnt_nxt;
      if (!pc_we && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    mdu_cnt_nxt = mdu_cnt;
    pc_we       = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    mdu_busy    = 1'b0;
    if (!resetn) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (jmp) begin
            pc_we       = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (lu) begin
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
          end else begin
            if (id_mdu) begin
              state_nxt   = MDU_WAIT;
              mdu_cnt_nxt = MDU_LOAD;
            end
            // The mult/div still issues to EX while the fetch is stalled.
            if (!imem_ready) begin
              ifid_flush = 1'b1;
            end else begin
              pc_we = 1'b1;
            end
          end
        end
        MDU_WAIT: begin
          mdu_busy    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
          mdu_cnt_nxt = mdu_cnt - 8'd1;
          if (mdu_cnt == 8'd1)
            state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [4:0] id_rs = 5'd1, id_rt = 5'd2, ex_rt = 5'd0;
  logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_mdu = 1'b0;
  logic       ex_mem_read = 1'b0, jmp = 1'b0, imem_ready = 1'b1;
  logic       pc_we, ifid_stall, ifid_flush, idex_bubble, mdu_busy;
  logic [3:0] stall_cnt;

  typedef struct {
    logic [4:0] ctl;
    int         cnt;
    string      name;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  pipe_hazard_ctrl #(.MDU_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_mdu(id_mdu), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .jmp(jmp),
    .imem_ready(imem_ready),
    .pc_we(pc_we), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // ctl order: {pc_we, ifid_stall, ifid_flush, idex_bubble, mdu_busy}
  always @(negedge clk) begin
    while (expq.size() > 0) begin
      exp_t e;
      logic [4:0] act;
      e   = expq.pop_front();
      act = {pc_we, ifid_stall, ifid_flush, idex_bubble, mdu_busy};
      checks++;
      if (act !== e.ctl || int'(stall_cnt) != e.cnt) begin
        errors++;
        $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                 e.name, act, stall_cnt, e.ctl, e.cnt);
      end
    end
  end

  task automatic cyc(input logic rn, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic mdu, input logic mr,
                     input logic [4:0] ert, input logic jp, input logic rdy,
                     input logic [4:0] ectl, input int ecnt, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    resetn = rn; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_mdu = mdu; ex_mem_read = mr; ex_rt = ert; jmp = jp; imem_ready = rdy;
    e.ctl = ectl; e.cnt = ecnt; e.name = nm;
    expq.push_back(e);
  endtask

  task automatic idle(input logic [4:0] ectl, input int ecnt, input string nm);
    cyc(1, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 1, ectl, ecnt, nm);
  endtask

  task automatic rst(input int ecnt, input string nm);
    cyc(0, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 1, 5'b00110, ecnt, nm);
  endtask

  initial begin
    int budget;
    rst(0, "reset0");
    rst(0, "reset1");
    // load-use and its corner cases
    cyc(1, 5'd5, 5'd0, 1, 0, 0, 1, 5'd5, 0, 1, 5'b01010, 0, "lu_rs");
    cyc(1, 5'd5, 5'd0, 1, 0, 0, 0, 5'd5, 0, 1, 5'b10000, 1, "lu_release");
    cyc(1, 5'd9, 5'd7, 0, 1, 0, 1, 5'd7, 0, 1, 5'b01010, 1, "lu_rt");
    cyc(1, 5'd9, 5'd7, 0, 0, 0, 1, 5'd7, 0, 1, 5'b10000, 2, "rt_unused");
    cyc(1, 5'd0, 5'd0, 1, 1, 0, 1, 5'd0, 0, 1, 5'b10000, 2, "reg0_excl");
    cyc(1, 5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 1, 1, 5'b10110, 2, "jmp_prio");
    idle(5'b10000, 2, "jmp_stays_run");
    cyc(1, 5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 0, 1, 5'b01010, 2, "lu_over_mdu");
    rst(3, "reset_cnt3");
    // mult/div occupancy, jmp ignored mid-wait
    cyc(1, 5'd1, 5'd2, 0, 0, 1, 0, 5'd0, 0, 1, 5'b10000, 0, "mdu_issue");
    idle(5'b01011, 0, "mdu_wait1");
    cyc(1, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 1, 1, 5'b01011, 1, "mdu_wait2_jmp");
    idle(5'b01011, 2, "mdu_wait3");
    idle(5'b10000, 3, "mdu_done");
    // imem wait
    cyc(1, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 0, 5'b00100, 3, "imem_wait1");
    cyc(1, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 0, 5'b00100, 4, "imem_wait2");
    idle(5'b10000, 5, "imem_resume");
    // mult/div issued while fetch waits
    cyc(1, 5'd1, 5'd2, 0, 0, 1, 0, 5'd0, 0, 0, 5'b00100, 5, "mdu_imem");
    idle(5'b01011, 6, "mdu_imem_w1");
    idle(5'b01011, 7, "mdu_imem_w2");
    idle(5'b01011, 8, "mdu_imem_w3");
    idle(5'b10000, 9, "mdu_imem_done");
    // reset aborts an MDU wait
    cyc(1, 5'd1, 5'd2, 0, 0, 1, 0, 5'd0, 0, 1, 5'b10000, 9, "mdu_issue2");
    idle(5'b01011, 9, "mdu2_wait1");
    rst(10, "reset_midwait");
    idle(5'b10000, 0, "after_abort");
    // saturation of the 4-bit counter
    for (int i = 0; i < 20; i++)
      cyc(1, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 0, 5'b00100, (i < 15) ? i : 15, "sat_stall");
    idle(5'b10000, 15, "sat_hold");
    budget = 20;
    while (expq.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (expq.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
